// File: rtl/mem_arbiter_if.sv
// Bundle of the two client ports (instruction fetch and data) and the shared
// memory port of mem_arbiter.
//   slave  : arbiter side (consumes client requests and memory completions).
//   master : environment side (clients plus shared memory).
// Client side : ireq/iaddr, dreq/dwr/daddr/dwdata, halt  -> arbiter
//               idone/irdata, ddone/drdata, istall/dstall, halt_idle, err <- arbiter
// Memory side : mem_req/mem_wr/mem_addr/mem_wdata <- arbiter
//               mem_done/mem_rdata -> arbiter
interface mem_arbiter_if;
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic        halt;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        idone;
    logic        ddone;
    logic [15:0] irdata;
    logic [15:0] drdata;
    logic        istall;
    logic        dstall;
    logic        halt_idle;
    logic        err;

    modport slave (
        input  ireq, iaddr, dreq, dwr, daddr, dwdata, halt, mem_done, mem_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata, idone, ddone, irdata, drdata,
               istall, dstall, halt_idle, err
    );

    modport master (
        output ireq, iaddr, dreq, dwr, daddr, dwdata, halt, mem_done, mem_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata, idone, ddone, irdata, drdata,
               istall, dstall, halt_idle, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / data) arbiter for a single shared memory.
// Data requests win by default; after DSTREAK consecutive data grants while a
// fetch is pending, the fetch wins once. A stuck memory (no mem_done within
// TIMEOUT busy cycles) or a spurious mem_done traps the arbiter in a sticky
// error state that only rst clears.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave, client and memory signals
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned DSTREAK = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [1:0]      StreakMax = 2'(DSTREAK);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StErr} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      streak_q, streak_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_wr_q, mem_wr_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    logic            idone_q, idone_d;
    logic            ddone_q, ddone_d;
    logic [15:0]     irdata_q, irdata_d;
    logic [15:0]     drdata_q, drdata_d;
    logic            err_q, err_d;
    logic            grant_i, grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            idone_q     <= idone_d;
            ddone_q     <= ddone_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_req_d   = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        idone_d     = 1'b0;
        ddone_d     = 1'b0;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        err_d       = err_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_done) begin
                    // Completion with nothing outstanding.
                    state_d = StErr;
                    err_d   = 1'b1;
                end else if (!idone_q && !ddone_q) begin
                    // No grant in the done-pulse cycle: the finishing client
                    // still holds its request level there.
                    grant_i = bus.ireq && !bus.halt && (!bus.dreq || streak_q == StreakMax);
                    grant_d = bus.dreq && !grant_i;
                    if (grant_i) begin
                        state_d     = StIBusy;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = bus.iaddr;
                        mem_wdata_d = '0;
                        cnt_d       = '0;
                        streak_d    = '0;
                    end else if (grant_d) begin
                        state_d     = StDBusy;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = bus.dwr;
                        mem_addr_d  = bus.daddr;
                        mem_wdata_d = bus.dwdata;
                        cnt_d       = '0;
                        if (!bus.ireq) begin
                            streak_d = '0;
                        end else if (streak_q != StreakMax) begin
                            streak_d = streak_q + 2'd1;
                        end
                    end
                end
            end
            StIBusy, StDBusy: begin
                if (bus.mem_done) begin
                    state_d = StIdle;
                    if (state_q == StIBusy) begin
                        irdata_d = bus.mem_rdata;
                        idone_d  = 1'b1;
                    end else begin
                        if (!mem_wr_q) begin
                            drdata_d = bus.mem_rdata;
                        end
                        ddone_d = 1'b1;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StErr: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = StErr;
                err_d   = 1'b1;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.idone     = idone_q;
    assign bus.ddone     = ddone_q;
    assign bus.irdata    = irdata_q;
    assign bus.drdata    = drdata_q;
    assign bus.err       = err_q;
    assign bus.istall    = bus.ireq & ~idone_q;
    assign bus.dstall    = bus.dreq & ~ddone_q;
    assign bus.halt_idle = (state_q == StIdle) & bus.halt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the
// falling clock edge, expected values written out by hand.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(64), .DSTREAK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge of the cycle in which mem_req is seen.
    task automatic wait_req(input string tag, output int n);
        n = 0;
        @(negedge clk);
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    endtask

    // From the mem_req cycle: hold off lat cycles, then one-cycle mem_done.
    // Returns at the falling edge of the done-pulse cycle.
    task automatic complete(input string tag, input int lat, input logic [15:0] rd,
                            input logic [15:0] addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i == 0) check_eq({tag, "_req1cyc"}, 32'(bus.mem_req), 32'd0);
            check_eq({tag, "_addr_hold"}, 32'(bus.mem_addr), 32'(addr));
        end
        bus.mem_done  = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [15:0] order [6];
        order[0] = 16'h0300; order[1] = 16'h0300; order[2] = 16'h0100;
        order[3] = 16'h0300; order[4] = 16'h0300; order[5] = 16'h0100;

        bus.ireq = 0; bus.iaddr = 0; bus.dreq = 0; bus.dwr = 0; bus.daddr = 0;
        bus.dwdata = 0; bus.halt = 0; bus.mem_done = 0; bus.mem_rdata = 0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_done", 32'({bus.idone, bus.ddone}), 32'd0);
        check_eq("rst_rdata", 32'({bus.irdata, bus.drdata}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch, memory answers 3 cycles after mem_req.
        bus.ireq = 1; bus.iaddr = 16'h0040;
        wait_req("i36", n);
        check_eq("i36_lat", 32'(n), 32'd0);
        check_eq("i36_wr", 32'(bus.mem_wr), 32'd0);
        check_eq("i36_addr", 32'(bus.mem_addr), 32'h0040);
        check_eq("i36_istall", 32'(bus.istall), 32'd1);
        complete("i36", 3, 16'h1234, 16'h0040);
        check_eq("i36_idone", 32'(bus.idone), 32'd1);
        check_eq("i36_irdata", 32'(bus.irdata), 32'h1234);
        check_eq("i36_istall_off", 32'(bus.istall), 32'd0);
        bus.ireq = 0;
        @(negedge clk);
        check_eq("i36_idone_1cyc", 32'(bus.idone), 32'd0);
        check_eq("i36_no_regrant", 32'(bus.mem_req), 32'd0);

        // Data read to give drdata a known value.
        bus.dreq = 1; bus.dwr = 0; bus.daddr = 16'h0010;
        wait_req("drd", n);
        check_eq("drd_wr", 32'(bus.mem_wr), 32'd0);
        complete("drd", 1, 16'h5A5A, 16'h0010);
        check_eq("drd_ddone", 32'(bus.ddone), 32'd1);
        check_eq("drd_drdata", 32'(bus.drdata), 32'h5A5A);
        bus.dreq = 0;
        @(negedge clk);

        // Simultaneous I and D write: D first, drdata untouched, then I.
        bus.ireq = 1; bus.iaddr = 16'h0200;
        bus.dreq = 1; bus.dwr = 1; bus.daddr = 16'h8000; bus.dwdata = 16'hBEEF;
        wait_req("d37", n);
        check_eq("d37_wr", 32'(bus.mem_wr), 32'd1);
        check_eq("d37_addr", 32'(bus.mem_addr), 32'h8000);
        check_eq("d37_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        complete("d37", 2, 16'hFFFF, 16'h8000);
        check_eq("d37_ddone", 32'(bus.ddone), 32'd1);
        check_eq("d37_drdata", 32'(bus.drdata), 32'h5A5A);
        check_eq("d37_idone", 32'(bus.idone), 32'd0);
        bus.dreq = 0; bus.dwr = 0;
        wait_req("i37", n);
        check_eq("i37_addr", 32'(bus.mem_addr), 32'h0200);
        check_eq("i37_wr", 32'(bus.mem_wr), 32'd0);
        check_eq("i37_wdata", 32'(bus.mem_wdata), 32'd0);
        complete("i37", 1, 16'h7777, 16'h0200);
        check_eq("i37_idone", 32'(bus.idone), 32'd1);
        check_eq("i37_irdata", 32'(bus.irdata), 32'h7777);
        bus.ireq = 0;
        @(negedge clk);

        // Both held continuously: D,D,I,D,D,I.
        bus.ireq = 1; bus.iaddr = 16'h0100;
        bus.dreq = 1; bus.dwr = 0; bus.daddr = 16'h0300;
        for (int i = 0; i < 6; i++) begin
            wait_req($sformatf("s38_%0d", i), n);
            check_eq($sformatf("s38_order%0d", i), 32'(bus.mem_addr), 32'(order[i]));
            complete($sformatf("s38_%0d", i), 1, 16'(i), order[i]);
        end
        bus.ireq = 0; bus.dreq = 0;
        @(negedge clk);
        @(negedge clk);

        // Halt blocks fetches until dropped.
        bus.halt = 1; bus.ireq = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("h39_no_req", 32'(bus.mem_req), 32'd0);
            check_eq("h39_halt_idle", 32'(bus.halt_idle), 32'd1);
            check_eq("h39_istall", 32'(bus.istall), 32'd1);
        end
        bus.halt = 0;
        @(negedge clk);
        check_eq("h39_grant", 32'(bus.mem_req), 32'd1);
        check_eq("h39_addr", 32'(bus.mem_addr), 32'h0100);
        check_eq("h39_halt_idle_off", 32'(bus.halt_idle), 32'd0);
        complete("h39", 1, 16'h0abc, 16'h0100);
        check_eq("h39_idone", 32'(bus.idone), 32'd1);
        bus.ireq = 0;
        @(negedge clk);

        // Reset in the middle of a data read.
        bus.dreq = 1; bus.dwr = 0; bus.daddr = 16'h0444;
        wait_req("r41", n);
        rst = 1'b1;
        #1;
        check_eq("r41_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("r41_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("r41_rdata", 32'({bus.irdata, bus.drdata}), 32'd0);
        check_eq("r41_err", 32'(bus.err), 32'd0);
        bus.dreq = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("r41_no_ddone", 32'(bus.ddone), 32'd0);
            check_eq("r41_idle", 32'(bus.mem_req), 32'd0);
        end

        // Memory never answers: err after 64 busy cycles, then sticky.
        bus.dreq = 1; bus.dwr = 1; bus.daddr = 16'h0900; bus.dwdata = 16'h1111;
        wait_req("t40", n);
        repeat (63) @(negedge clk);
        check_eq("t40_err_early", 32'(bus.err), 32'd0);
        @(negedge clk);
        check_eq("t40_err", 32'(bus.err), 32'd1);
        bus.dreq = 0; bus.ireq = 1; bus.iaddr = 16'h0008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t40_no_req", 32'(bus.mem_req), 32'd0);
            check_eq("t40_no_idone", 32'(bus.idone), 32'd0);
            check_eq("t40_sticky", 32'(bus.err), 32'd1);
        end
        bus.ireq = 0;
        do_reset();
        check_eq("t40_err_clr", 32'(bus.err), 32'd0);

        // Spurious completion while idle.
        bus.mem_done = 1'b1;
        @(negedge clk);
        bus.mem_done = 1'b0;
        check_eq("sp_err", 32'(bus.err), 32'd1);
        check_eq("sp_no_done", 32'({bus.idone, bus.ddone}), 32'd0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
